bch_err_correct: RTL

Downstream correction stage of the BCH decoder. Buffers the serial received codeword while syndrome computation, Berlekamp-Massey and the Chien search (`chien`) run. Then XORs each buffered bit with the per-bit `err` strobe from the Chien search to emit the corrected codeword, one bit per cycle. Also provides flow control, alignment checking and an optional per-codeword error count.

---
 rtl/bch_err_correct.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/bch_err_correct.sv
// BCH correction stage: buffers received codeword bits and XORs each with the Chien err strobe on readout.
// Define BCH_CORR_ERRCNT_EN to build the per-codeword corrected-bit counter; otherwise err_cnt is tied to 0.
module bch_err_correct #(
    parameter int N     = 15,
    parameter int DEPTH = 2,
    parameter int CW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic          in_first,
    input  logic          in_bit,
    output logic          in_ready,
    input  logic          err_valid,
    input  logic          err_first,
    input  logic          err,
    output logic          out_valid,
    output logic          out_first,
    output logic          out_last,
    output logic          out_bit,
    output logic [CW-1:0] err_cnt,
    output logic          overflow,
    output logic          underflow,
    output logic          sync_err
);
    localparam int SIZE = DEPTH * N;
    localparam int AW   = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int CNTW = $clog2(SIZE + 1);
    localparam int IW   = (N > 1) ? $clog2(N) : 1;

    localparam logic [AW-1:0]   PTR_LAST = AW'(SIZE - 1);
    localparam logic [CNTW-1:0] CNT_FULL = CNTW'(SIZE);
    localparam logic [IW-1:0]   IDX_LAST = IW'(N - 1);

    logic            r_mem [SIZE];
    logic [AW-1:0]   r_wp;
    logic [AW-1:0]   r_rp;
    logic [CNTW-1:0] r_count;
    logic [IW-1:0]   r_wi;
    logic [IW-1:0]   r_ri;
    logic            r_out_valid;
    logic            r_out_first;
    logic            r_out_last;
    logic            r_out_bit;
    logic            r_overflow;
    logic            r_underflow;
    logic            r_sync_err;

    logic            w_ready;
    logic            w_empty;
    logic            w_wr;
    logic            w_rd;
    logic            w_wi_zero;
    logic            w_ri_zero;
    logic            w_ri_last;
    logic            w_sync_hit;
    logic [CNTW-1:0] w_count_next;

    // Ready depends only on the registered occupancy, so a same-cycle read never frees a slot for a write.
    assign w_ready   = (r_count < CNT_FULL);
    assign w_empty   = (r_count == '0);
    assign w_wr      = in_valid && w_ready;
    assign w_rd      = err_valid && !w_empty;
    assign w_wi_zero = (r_wi == '0);
    assign w_ri_zero = (r_ri == '0);
    assign w_ri_last = (r_ri == IDX_LAST);

    always_comb begin
        w_count_next = r_count;
        case ({w_wr, w_rd})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase
    end

    always_comb begin
        w_sync_hit = 1'b0;
        if (w_wr && (in_first != w_wi_zero)) begin
            w_sync_hit = 1'b1;
        end
        if (w_rd && (err_first != w_ri_zero)) begin
            w_sync_hit = 1'b1;
        end
    end

    // Storage carries no reset; occupancy and pointers decide what is meaningful.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wp] <= in_bit;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
            r_wi    <= '0;
            r_ri    <= '0;
        end else begin
            r_count <= w_count_next;
            if (w_wr) begin
                r_wp <= (r_wp == PTR_LAST) ? '0 : r_wp + 1'b1;
                r_wi <= (r_wi == IDX_LAST) ? '0 : r_wi + 1'b1;
            end
            if (w_rd) begin
                r_rp <= (r_rp == PTR_LAST) ? '0 : r_rp + 1'b1;
                r_ri <= (r_ri == IDX_LAST) ? '0 : r_ri + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_first <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_bit   <= 1'b0;
        end else begin
            r_out_valid <= w_rd;
            r_out_first <= w_rd && w_ri_zero;
            r_out_last  <= w_rd && w_ri_last;
            r_out_bit   <= w_rd && (r_mem[r_rp] ^ err);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_sync_err  <= 1'b0;
        end else begin
            if (in_valid && !w_ready) begin
                r_overflow <= 1'b1;
            end
            if (err_valid && w_empty) begin
                r_underflow <= 1'b1;
            end
            if (w_sync_hit) begin
                r_sync_err <= 1'b1;
            end
        end
    end

`ifdef BCH_CORR_ERRCNT_EN
    logic [CW-1:0] r_acc;
    logic [CW-1:0] r_err_cnt;
    logic [CW-1:0] w_acc_next;

    // Saturating add; the completed sum includes the last bit of the codeword.
    always_comb begin
        w_acc_next = r_acc;
        if (err && (r_acc != {CW{1'b1}})) begin
            w_acc_next = r_acc + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc     <= '0;
            r_err_cnt <= '0;
        end else if (w_rd) begin
            if (w_ri_last) begin
                r_err_cnt <= w_acc_next;
                r_acc     <= '0;
            end else begin
                r_acc <= w_acc_next;
            end
        end
    end

    assign err_cnt = r_err_cnt;
`else
    assign err_cnt = '0;
`endif

    assign in_ready  = w_ready;
    assign out_valid = r_out_valid;
    assign out_first = r_out_first;
    assign out_last  = r_out_last;
    assign out_bit   = r_out_bit;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;
    assign sync_err  = r_sync_err;

endmodule
